// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, ALU-op codes and per-stage control-word types for pipe_ctrl_unit.
// The optional j instruction is enabled by defining CTRL_JUMP_EN.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       writereg_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg_sel;
    logic       branch;
    logic       jump;
  } ctrl_word_t;

  // Later stages only carry the bits they or their successors consume.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg_sel;
  } ex_word_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg_sel;
  } mem_word_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg_sel;
  } wb_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = ctrl_word_t'(10'b0);
  localparam ex_word_t   EX_BUBBLE   = ex_word_t'(9'b0);
  localparam mem_word_t  MEM_BUBBLE  = mem_word_t'(4'b0);
  localparam wb_word_t   WB_BUBBLE   = wb_word_t'(2'b0);

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational ID-stage opcode decoder: control word, rt-as-source flag and illegal flag.
// Opcode 000010 (j) is legal only when CTRL_JUMP_EN is defined.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output ctrl_word_t o_ctrl,
  output logic       o_uses_rt,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = CTRL_BUBBLE;
    o_uses_rt = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.reg_write      = 1'b1;
        o_ctrl.writereg_sel   = 1'b1;
        o_ctrl.alu_op         = ALUOP_RTYPE;
        o_ctrl.mem_to_reg_sel = 1'b1;
        o_uses_rt             = 1'b1;
      end
      OP_LW: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      OP_SW: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_uses_rt        = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = ALUOP_SUB;
        o_uses_rt     = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        o_ctrl.reg_write      = 1'b1;
        o_ctrl.alu_src        = 1'b1;
        o_ctrl.alu_op         = ALUOP_IMM;
        o_ctrl.mem_to_reg_sel = 1'b1;
      end
      OP_J: begin
`ifdef CTRL_JUMP_EN
        o_ctrl.jump = 1'b1;
`else
        o_illegal = 1'b1;
`endif
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control unit: decode, ID/EX-EX/MEM-MEM/WB control registers, load-use stall,
// branch/jump flush and global hold. j support is enabled by defining CTRL_JUMP_EN.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LU_DEPTH   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_hold,
  input  logic                  i_id_valid,
  input  logic [5:0]            i_id_opcode,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_ex_branch_taken,
  output logic                  o_stall,
  output logic                  o_flush_ifid,
  output logic                  o_id_illegal,
  output logic [1:0]            o_ex_alu_op,
  output logic                  o_ex_alu_src,
  output logic                  o_ex_branch,
  output logic                  o_ex_jump,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic                  o_wb_reg_write,
  output logic                  o_wb_mem_to_reg_sel,
  output logic [REG_ADDR_W-1:0] o_ex_dst,
  output logic [REG_ADDR_W-1:0] o_mem_dst,
  output logic [REG_ADDR_W-1:0] o_wb_dst
);

  localparam logic [REG_ADDR_W-1:0] DST_NONE = {REG_ADDR_W{1'b0}};

  ctrl_word_t            w_dec_ctrl;
  logic                  w_uses_rt;
  logic                  w_dec_illegal;
  logic [REG_ADDR_W-1:0] w_id_dst;
  logic                  w_lu_ex;
  logic                  w_lu_mem;
  logic                  w_lu;
  ex_word_t              w_idex;
  logic [REG_ADDR_W-1:0] w_idex_dst;

  ex_word_t              r_ex;
  mem_word_t             r_mem;
  wb_word_t              r_wb;
  logic [REG_ADDR_W-1:0] r_ex_dst;
  logic [REG_ADDR_W-1:0] r_mem_dst;
  logic [REG_ADDR_W-1:0] r_wb_dst;

  pipe_ctrl_decode u_decode (
    .i_opcode  (i_id_opcode),
    .o_ctrl    (w_dec_ctrl),
    .o_uses_rt (w_uses_rt),
    .o_illegal (w_dec_illegal)
  );

  assign w_id_dst = w_dec_ctrl.writereg_sel ? i_id_rd : i_id_rt;

  // rt only counts as a source for opcodes that actually read it.
  assign w_lu_ex = r_ex.mem_read && (r_ex_dst != DST_NONE) &&
                   ((r_ex_dst == i_id_rs) || (w_uses_rt && (r_ex_dst == i_id_rt)));

  generate
    if (LU_DEPTH >= 2) begin : g_lu_mem
      assign w_lu_mem = r_mem.mem_read && (r_mem_dst != DST_NONE) &&
                        ((r_mem_dst == i_id_rs) || (w_uses_rt && (r_mem_dst == i_id_rt)));
    end else begin : g_no_lu_mem
      assign w_lu_mem = 1'b0;
    end
  endgenerate

  assign w_lu = i_id_valid && (w_lu_ex || w_lu_mem);

  // Front-end controls, resolved in priority order rst > hold > branch > load-use.
  always_comb begin
    o_stall      = 1'b0;
    o_flush_ifid = 1'b0;
    o_id_illegal = 1'b0;
    if (i_rst) begin
      o_stall      = 1'b0;
      o_flush_ifid = 1'b0;
    end else if (i_hold) begin
      o_stall      = 1'b1;
      o_id_illegal = i_id_valid && w_dec_illegal;
    end else if (i_ex_branch_taken) begin
      o_flush_ifid = 1'b1;
      o_id_illegal = i_id_valid && w_dec_illegal;
    end else if (w_lu) begin
      o_stall      = 1'b1;
      o_id_illegal = i_id_valid && w_dec_illegal;
    end else begin
      o_flush_ifid = i_id_valid && w_dec_ctrl.jump;
      o_id_illegal = i_id_valid && w_dec_illegal;
    end
  end

  // Word entering ID/EX; illegal opcodes enter as a full bubble including dst.
  always_comb begin
    w_idex     = EX_BUBBLE;
    w_idex_dst = DST_NONE;
    if (i_ex_branch_taken || w_lu || !i_id_valid || w_dec_illegal) begin
      w_idex     = EX_BUBBLE;
      w_idex_dst = DST_NONE;
    end else begin
      w_idex.alu_op         = w_dec_ctrl.alu_op;
      w_idex.alu_src        = w_dec_ctrl.alu_src;
      w_idex.branch         = w_dec_ctrl.branch;
      w_idex.mem_read       = w_dec_ctrl.mem_read;
      w_idex.mem_write      = w_dec_ctrl.mem_write;
      w_idex.reg_write      = w_dec_ctrl.reg_write;
      w_idex.mem_to_reg_sel = w_dec_ctrl.mem_to_reg_sel;
`ifdef CTRL_JUMP_EN
      w_idex.jump           = w_dec_ctrl.jump;
`else
      w_idex.jump           = 1'b0;
`endif
      w_idex_dst            = w_id_dst;
    end
  end

  // Stage registers: cleared on reset, frozen on hold, otherwise shift one stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex      <= EX_BUBBLE;
      r_ex_dst  <= DST_NONE;
      r_mem     <= MEM_BUBBLE;
      r_mem_dst <= DST_NONE;
      r_wb      <= WB_BUBBLE;
      r_wb_dst  <= DST_NONE;
    end else if (!i_hold) begin
      r_ex                 <= w_idex;
      r_ex_dst             <= w_idex_dst;
      r_mem.mem_read       <= r_ex.mem_read;
      r_mem.mem_write      <= r_ex.mem_write;
      r_mem.reg_write      <= r_ex.reg_write;
      r_mem.mem_to_reg_sel <= r_ex.mem_to_reg_sel;
      r_mem_dst            <= r_ex_dst;
      r_wb.reg_write       <= r_mem.reg_write;
      r_wb.mem_to_reg_sel  <= r_mem.mem_to_reg_sel;
      r_wb_dst             <= r_mem_dst;
    end
  end

  assign o_ex_alu_op         = r_ex.alu_op;
  assign o_ex_alu_src        = r_ex.alu_src;
  assign o_ex_branch         = r_ex.branch;
  assign o_ex_jump           = r_ex.jump;
  assign o_ex_dst            = r_ex_dst;
  assign o_mem_read          = r_mem.mem_read;
  assign o_mem_write         = r_mem.mem_write;
  assign o_mem_dst           = r_mem_dst;
  assign o_wb_reg_write      = r_wb.reg_write;
  assign o_wb_mem_to_reg_sel = r_wb.mem_to_reg_sel;
  assign o_wb_dst            = r_wb_dst;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: directed per-cycle vectors with hand-computed expectations,
// checked by a negedge monitor. A second instance with LU_DEPTH=2 shares the stimulus.
module tb_pipe_ctrl_unit;

  localparam int W = 5;
  localparam int K_BUB = 0, K_ADD = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_ADDI = 5, K_J = 6;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, ILL = 6'b111111, JOP = 6'b000010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hold, id_valid, br;
  logic [5:0] opcode;
  logic [W-1:0] rs, rt, rd;

  logic stall, flush, ill, ex_alu_src, ex_branch, ex_jump, mem_read, mem_write, wb_rw, wb_m2r;
  logic [1:0] ex_alu_op;
  logic [W-1:0] ex_dst, mem_dst, wb_dst;

  logic d2_stall, d2_flush, d2_ill, d2_alu_src, d2_branch, d2_jump, d2_mr, d2_mw, d2_rw, d2_m2r;
  logic [1:0] d2_alu_op;
  logic [W-1:0] d2_ex_dst, d2_mem_dst, d2_wb_dst;

  pipe_ctrl_unit #(.REG_ADDR_W(W), .LU_DEPTH(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_id_valid(id_valid), .i_id_opcode(opcode),
    .i_id_rs(rs), .i_id_rt(rt), .i_id_rd(rd), .i_ex_branch_taken(br),
    .o_stall(stall), .o_flush_ifid(flush), .o_id_illegal(ill),
    .o_ex_alu_op(ex_alu_op), .o_ex_alu_src(ex_alu_src), .o_ex_branch(ex_branch), .o_ex_jump(ex_jump),
    .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_wb_reg_write(wb_rw), .o_wb_mem_to_reg_sel(wb_m2r),
    .o_ex_dst(ex_dst), .o_mem_dst(mem_dst), .o_wb_dst(wb_dst)
  );

  pipe_ctrl_unit #(.REG_ADDR_W(W), .LU_DEPTH(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_id_valid(id_valid), .i_id_opcode(opcode),
    .i_id_rs(rs), .i_id_rt(rt), .i_id_rd(rd), .i_ex_branch_taken(br),
    .o_stall(d2_stall), .o_flush_ifid(d2_flush), .o_id_illegal(d2_ill),
    .o_ex_alu_op(d2_alu_op), .o_ex_alu_src(d2_alu_src), .o_ex_branch(d2_branch), .o_ex_jump(d2_jump),
    .o_mem_read(d2_mr), .o_mem_write(d2_mw),
    .o_wb_reg_write(d2_rw), .o_wb_mem_to_reg_sel(d2_m2r),
    .o_ex_dst(d2_ex_dst), .o_mem_dst(d2_mem_dst), .o_wb_dst(d2_wb_dst)
  );

  typedef struct {
    bit rst; bit hold; bit valid; logic [5:0] op; logic [W-1:0] rs; logic [W-1:0] rt; logic [W-1:0] rd; bit br;
    bit e_stall; bit e_stall2; bit e_flush; bit e_ill; int load; logic [W-1:0] dst;
  } vec_t;

  typedef struct {
    int idx; bit stall; bit stall2; bit flush; bit ill;
    logic [4:0] ex_f; logic [W-1:0] ex_d; logic [1:0] mem_f; logic [W-1:0] mem_d;
    logic [1:0] wb_f; logic [W-1:0] wb_d; bit chk_reg;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  // {alu_op, alu_src, branch, jump, mem_read, mem_write, reg_write, mem_to_reg_sel}
  function automatic logic [8:0] fields(input int k);
    case (k)
      K_ADD:   return 9'b10_000_00_11;
      K_LW:    return 9'b00_100_10_10;
      K_SW:    return 9'b00_100_01_00;
      K_BEQ:   return 9'b01_010_00_00;
      K_ADDI:  return 9'b11_100_00_11;
      K_J:     return 9'b00_001_00_00;
      default: return 9'b00_000_00_00;
    endcase
  endfunction

  task automatic add_v(input bit r, input bit h, input bit v, input logic [5:0] op,
                       input logic [W-1:0] s, input logic [W-1:0] t, input logic [W-1:0] d, input bit b,
                       input bit es, input bit es2, input bit ef, input bit ei, input int ld, input logic [W-1:0] dst);
    vec_t x;
    x.rst = r; x.hold = h; x.valid = v; x.op = op; x.rs = s; x.rt = t; x.rd = d; x.br = b;
    x.e_stall = es; x.e_stall2 = es2; x.e_flush = ef; x.e_ill = ei; x.load = ld; x.dst = dst;
    vecs.push_back(x);
  endtask

  task automatic check(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Monitor: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("stall", e.idx, {7'b0, stall}, {7'b0, e.stall});
      check("stall_lu2", e.idx, {7'b0, d2_stall}, {7'b0, e.stall2});
      check("flush", e.idx, {7'b0, flush}, {7'b0, e.flush});
      check("flush_lu2", e.idx, {7'b0, d2_flush}, {7'b0, e.flush});
      check("illegal", e.idx, {7'b0, ill}, {7'b0, e.ill});
      if (e.chk_reg) begin
        check("ex_ctrl", e.idx, {3'b0, ex_alu_op, ex_alu_src, ex_branch, ex_jump}, {3'b0, e.ex_f});
        check("ex_dst", e.idx, {3'b0, ex_dst}, {3'b0, e.ex_d});
        check("mem_ctrl", e.idx, {6'b0, mem_read, mem_write}, {6'b0, e.mem_f});
        check("mem_dst", e.idx, {3'b0, mem_dst}, {3'b0, e.mem_d});
        check("wb_ctrl", e.idx, {6'b0, wb_rw, wb_m2r}, {6'b0, e.wb_f});
        check("wb_dst", e.idx, {3'b0, wb_dst}, {3'b0, e.wb_d});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : drv
    int ex_k, mem_k, wb_k;
    logic [W-1:0] ex_d, mem_d, wb_d;
    logic [8:0] f;
    bit known;
    exp_t e;
    rst = 1'b1; hold = 1'b0; id_valid = 1'b0; opcode = R; rs = '0; rt = '0; rd = '0; br = 1'b0;
    ex_k = K_BUB; mem_k = K_BUB; wb_k = K_BUB; ex_d = '0; mem_d = '0; wb_d = '0; known = 1'b0;

    //     rst hold v  op    rs  rt  rd br  st st2 fl il  load    dst
    add_v(1, 0, 0, R,    0,  0,  0, 0,  0, 0, 0, 0, K_BUB,  0);
    add_v(1, 0, 1, ILL,  1,  2,  3, 1,  0, 0, 0, 0, K_BUB,  0);
    add_v(0, 0, 1, R,    1,  2,  3, 0,  0, 0, 0, 0, K_ADD,  3);
    add_v(0, 0, 1, LW,   1,  4,  0, 0,  0, 0, 0, 0, K_LW,   4);
    add_v(0, 0, 1, SW,   2,  6,  0, 0,  0, 0, 0, 0, K_SW,   6);
    add_v(0, 0, 1, BEQ,  7,  8,  0, 0,  0, 0, 0, 0, K_BEQ,  8);
    add_v(0, 0, 1, ADDI, 1,  9,  0, 0,  0, 0, 0, 0, K_ADDI, 9);
    add_v(0, 0, 0, R,    0,  0,  0, 0,  0, 0, 0, 0, K_BUB,  0);
    add_v(0, 0, 1, LW,   1,  5,  0, 0,  0, 0, 0, 0, K_LW,   5);
    add_v(0, 0, 1, R,    5,  2, 10, 0,  1, 1, 0, 0, K_BUB,  0);
    add_v(0, 0, 1, R,    5,  2, 10, 0,  0, 1, 0, 0, K_ADD, 10);
    add_v(0, 0, 1, LW,   1,  5,  0, 0,  0, 0, 0, 0, K_LW,   5);
    add_v(0, 0, 1, R,    6,  7, 11, 0,  0, 0, 0, 0, K_ADD, 11);
    add_v(0, 0, 1, LW,   1,  5,  0, 0,  0, 0, 0, 0, K_LW,   5);
    add_v(0, 0, 1, ADDI, 1,  5,  0, 0,  0, 0, 0, 0, K_ADDI, 5);
    add_v(0, 0, 1, LW,   1,  5,  0, 0,  0, 0, 0, 0, K_LW,   5);
    add_v(0, 0, 1, SW,   2,  5,  0, 0,  1, 1, 0, 0, K_BUB,  0);
    add_v(0, 0, 1, SW,   2,  5,  0, 0,  0, 1, 0, 0, K_SW,   5);
    add_v(0, 0, 1, LW,   1, 12,  0, 0,  0, 0, 0, 0, K_LW,  12);
    add_v(0, 0, 1, R,   12,  2, 13, 1,  0, 0, 1, 0, K_BUB,  0);
    add_v(0, 0, 1, R,   12,  2, 13, 0,  0, 1, 0, 0, K_ADD, 13);
    add_v(0, 0, 1, ADDI, 1, 14,  0, 0,  0, 0, 0, 0, K_ADDI,14);
    add_v(0, 0, 1, SW,   1, 15,  0, 0,  0, 0, 0, 0, K_SW,  15);
    for (int i = 0; i < 3; i++)
      add_v(0, 1, 1, R,  1,  2, 16, 1,  1, 1, 0, 0, K_BUB,  0);
    add_v(0, 0, 1, R,    1,  2, 16, 0,  0, 0, 0, 0, K_ADD, 16);
    add_v(0, 0, 0, R,    0,  0,  0, 0,  0, 0, 0, 0, K_BUB,  0);
    add_v(0, 0, 1, ILL,  0,  0,  0, 0,  0, 0, 0, 1, K_BUB,  0);
`ifdef CTRL_JUMP_EN
    add_v(0, 0, 1, JOP,  0,  0,  0, 0,  0, 0, 1, 0, K_J,    0);
`else
    add_v(0, 0, 1, JOP,  0,  0,  0, 0,  0, 0, 0, 1, K_BUB,  0);
`endif
    for (int i = 0; i < 3; i++)
      add_v(0, 0, 0, R,  0,  0,  0, 0,  0, 0, 0, 0, K_BUB,  0);
    add_v(0, 0, 1, R,    1,  2, 17, 0,  0, 0, 0, 0, K_ADD, 17);
    add_v(0, 0, 1, LW,   1, 18,  0, 0,  0, 0, 0, 0, K_LW,  18);
    add_v(1, 0, 1, R,   18,  2, 19, 0,  0, 0, 0, 0, K_BUB,  0);
    add_v(0, 0, 1, R,   18,  2, 19, 0,  0, 0, 0, 0, K_ADD, 19);
    add_v(0, 0, 0, R,    0,  0,  0, 0,  0, 0, 0, 0, K_BUB,  0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; hold = vecs[i].hold; id_valid = vecs[i].valid; opcode = vecs[i].op;
      rs = vecs[i].rs; rt = vecs[i].rt; rd = vecs[i].rd; br = vecs[i].br;
      e.idx = i; e.stall = vecs[i].e_stall; e.stall2 = vecs[i].e_stall2;
      e.flush = vecs[i].e_flush; e.ill = vecs[i].e_ill; e.chk_reg = known;
      f = fields(ex_k);  e.ex_f = f[8:4];  e.ex_d = ex_d;
      f = fields(mem_k); e.mem_f = f[3:2]; e.mem_d = mem_d;
      f = fields(wb_k);  e.wb_f = f[1:0];  e.wb_d = wb_d;
      sb.push_back(e);
      if (vecs[i].rst) begin
        ex_k = K_BUB; mem_k = K_BUB; wb_k = K_BUB; ex_d = '0; mem_d = '0; wb_d = '0; known = 1'b1;
      end else if (!vecs[i].hold) begin
        wb_k = mem_k; wb_d = mem_d; mem_k = ex_k; mem_d = ex_d; ex_k = vecs[i].load; ex_d = vecs[i].dst;
      end
    end
    @(posedge clk);
    #1;
    id_valid = 1'b0; hold = 1'b0; br = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", -1, 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the combinational MIPS opcode decoder.
- Decodes the ID-stage opcode into a control word and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Adds load-use hazard detection, bubble insertion, branch/jump flush, a global hold, and an illegal-opcode flag.
- Sits beside the datapath pipeline registers. Drives the PC/IF-ID enables and every stage's control inputs.

Parameters:
- REG_ADDR_W, 5, register-address width (rs/rt/rd/dst).
- LU_DEPTH, 1, load-use window. 1 = compare against the EX-stage load only (MEM-to-EX forwarding exists). 2 = also compare against the MEM-stage load (no load forwarding).

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  synchronous reset, active-high.
- hold  in  1  external freeze (memory wait); all control registers keep their value.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  6  instruction[31:26].
- id_rs, id_rt, id_rd  in  REG_ADDR_W each  source/destination fields.
- ex_branch_taken  in  1  beq resolved taken in EX this cycle.
- stall  out  1  hold PC and IF/ID (combinational).
- flush_ifid  out  1  clear IF/ID next edge (combinational).
- id_illegal  out  1  valid but undecodable opcode in ID (combinational).
- ex_alu_op  out  2; ex_alu_src  out  1; ex_branch  out  1; ex_jump  out  1.
- mem_read, mem_write  out  1 each  MEM-stage controls.
- wb_reg_write, wb_mem_to_reg_sel  out  1 each  WB-stage controls.
- ex_dst, mem_dst, wb_dst  out  REG_ADDR_W each  destination register per stage.

Behaviour:
- Decode (combinational, no X outputs):
  - R-type 000000: reg_write=1, writereg_sel=1 (rd), alu_src=0, alu_op=10, mem_to_reg_sel=1, uses_rt=1.
  - lw 100011: reg_write=1, mem_read=1, alu_src=1, alu_op=00, writereg_sel=0 (rt), mem_to_reg_sel=0, uses_rt=0.
  - sw 101011: mem_write=1, alu_src=1, alu_op=00, uses_rt=1.
  - beq 000100: branch=1, alu_op=01, uses_rt=1.
  - addi/andi/ori/slti 001000/001100/001101/001010: reg_write=1, alu_src=1, alu_op=11, writereg_sel=0, mem_to_reg_sel=1, uses_rt=0.
  - Any other opcode: all-zero word. id_illegal=id_valid.
  - All control bits not listed for a given opcode are 0.
- dst = writereg_sel ? rd : rt. A word with dst==0 and reg_write=1 is carried unchanged; the register file ignores r0.
- Bubble = all-zero control word with dst=0.
- Load-use hazard (lu):
  - Condition: ex_mem_read, ex_dst!=0, and (ex_dst==id_rs, or uses_rt and ex_dst==id_rt).
  - LU_DEPTH=2 adds the same test against mem_read/mem_dst.
  - lu requires id_valid.
- Priority per cycle:
  1. rst: all registers cleared; stall=flush_ifid=id_illegal=0.
  2. hold: every register holds; stall=1, flush_ifid=0.
  3. ex_branch_taken: flush_ifid=1; ID/EX loads bubble; stall=0; lu ignored.
  4. lu: stall=1; ID/EX loads bubble; flush_ifid=0.
  5. Otherwise: ID/EX loads the decoded word (bubble if !id_valid). flush_ifid=id jump (when jump is compiled in).
- Stage shift on every non-hold edge: EX/MEM <= ID/EX, MEM/WB <= EX/MEM.
- Latency: decoded word reaches ex_* after 1 edge, mem_* after 2, wb_* after 3.
- Reset values: all outputs 0. Reset asserted mid-stream discards all in-flight words within one edge.
- Simultaneous branch_taken and hold: hold wins; the branch is re-presented by the datapath.

Optional Feature:
- CTRL_JUMP_EN defined: opcode 000010 (j) decodes to jump=1, all other bits 0. It is not illegal, causes flush_ifid=1 in ID, and ex_jump follows 1 edge later.
- Undefined: 000010 is illegal, and ex_jump is tied to 0.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J;
  - ALUOP_* constants;
  - ctrl_word_t struct and the CTRL_BUBBLE constant.
- One sub-module, pipe_ctrl_decode: purely combinational opcode to ctrl_word_t, uses_rt and illegal.
- Hazard logic and the stage registers stay in the top module.

Test Plan:
- Reset: hold rst 2 cycles, then sequence add, lw, sw, beq, addi, each id_valid=1 -> ex_alu_op=10,00,00,01,11 on consecutive cycles. wb_reg_write pattern is 1,1,0,0,1 three edges after each instruction's decode. All outputs 0 during rst.
- Load-use: lw rt=5, then add rs=5 -> stall=1 for 1 cycle and a bubble in EX. With LU_DEPTH=2 -> stall for 2 cycles. If add uses rs=6 and rt=7 -> no stall.
- No false stall on rt: lw rt=5, then addi rt=5 (rt is a destination) -> stall=0. lw rt=5, then sw rt=5 -> stall=1.
- Branch flush: ex_branch_taken=1 with lu also true -> flush_ifid=1, stall=0, next ex_* all 0.
- Hold: hold=1 for 3 cycles mid-stream -> ex_*/mem_*/wb_* and dst values frozen and stall=1. Stream resumes unchanged afterwards.
- Illegal/jump: opcode 111111 valid -> id_illegal=1 and a bubble propagates. Opcode 000010 -> with CTRL_JUMP_EN: flush_ifid=1, ex_jump=1 next cycle; without it: id_illegal=1.
